// File: rtl/memory_pkg.sv
// Shared definitions for the DataMemory burst reader: memory geometry,
// word/address types and the reader FSM state encoding.
package memory_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry output buffer for the memory reader. The head word is held in a
// register and drives the streamed output directly, so it stays stable while
// the consumer stalls. Occupancy is exported so the reader can budget reads.
module rd_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_valid,
  output logic [1:0]        o_occ
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_occ;

  // Head word and occupancy; the reader never pushes into a full buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_head <= '0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_push) begin
            r_head <= i_din;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_din;
          end else if (i_push) begin
            r_occ <= 2'd2;
          end else if (i_pop) begin
            r_occ <= 2'd0;
          end
        end
        default: begin
          if (i_pop) begin
            r_head <= r_tail;
            r_occ  <= i_push ? 2'd2 : 2'd1;
          end
        end
      endcase
    end
  end

  // Second slot only ever holds data behind a valid head, so it needs no reset
  always_ff @(posedge clk) begin
    if ((r_occ == 2'd1 && i_push && !i_pop) || (r_occ == 2'd2 && i_push && i_pop)) begin
      r_tail <= i_din;
    end
  end

  assign o_head  = r_head;
  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);

endmodule

// File: rtl/memory_reader.sv
// Sequential burst reader for the single-port DataMemory. Issues one address
// per cycle while credit allows (reads in flight plus buffered words <= 2),
// captures ram_q one edge after each issue and streams words in order on a
// valid/ready port.
// Configuration: define MEMORY_READER_WRAP_EN to let bursts wrap 255 -> 0;
// otherwise bursts are truncated at the top address.
module memory_reader
  import memory_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  reader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_inflight;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_occ;
  logic              w_pop;
  logic [2:0]        w_load;
  logic              w_issue;
  logic [ADDR_W:0]   w_eff_count;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W:0]   w_cnt_one;

  assign w_cnt_one = {{ADDR_W{1'b0}}, 1'b1};

`ifdef MEMORY_READER_WRAP_EN
  assign w_eff_count = count;
  assign w_next_addr = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
  logic [ADDR_W:0] w_room;
  assign w_room      = {1'b1, {ADDR_W{1'b0}}} - {1'b0, base};
  assign w_eff_count = (count < w_room) ? count : w_room;
  assign w_next_addr = (r_addr == {ADDR_W{1'b1}}) ? r_addr
                                                  : r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  // A word leaves the buffer on every edge where valid and ready coincide; a
  // pop on the same edge frees a slot, which keeps full rate under ready=1.
  assign w_pop   = dout_valid & dout_ready;
  assign w_load  = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_issue = (r_state == RUN) &&
                   ((w_load < 3'd2) || ((w_load == 3'd2) && w_pop));

  // Burst control: start acceptance, address issue, drain and completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_addr   <= base;
              r_remain <= w_eff_count;
              r_busy   <= 1'b1;
              r_state  <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_addr   <= w_next_addr;
            r_remain <= r_remain - w_cnt_one;
            if (r_remain == w_cnt_one) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_inflight && ((w_occ == 2'd1 && w_pop) || w_occ == 2'd0)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (r_inflight),
    .i_din   (ram_q),
    .i_pop   (w_pop),
    .o_head  (dout),
    .o_valid (dout_valid),
    .o_occ   (w_occ)
  );

  assign ram_addr = r_addr;
  assign ram_wren = 1'b0;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_memory_reader.sv
// Directed testbench for memory_reader with a registered-read RAM model
// preloaded with mem[i] = i*3.
module tb_memory_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base;
  logic [8:0]  count;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] got[$];
  int first_k, done_k, done_pulses, stable_err, busy0, busy_done, addr7;

  memory_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .count      (count),
    .ram_addr   (ram_addr),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
  end

  always @(posedge clk) ram_q <= mem[ram_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one burst and records what the consumer saw. k counts negedges after
  // the start-accepting edge E0 (k=0 is just after E0).
  // rmode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 ready=0 until k=8.
  task automatic run_burst(input logic [7:0] b, input logic [8:0] c,
                           input int rmode, input bit inject, input int max_k);
    logic        pv, pr, r;
    logic [15:0] pd;
    int          tail;
    got.delete();
    first_k = -1; done_k = -1; done_pulses = 0; stable_err = 0;
    busy0 = -1; busy_done = -1; addr7 = -1;
    @(negedge clk);
    start = 1'b1; base = b; count = c; dout_ready = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; tail = 0;
    for (int k = 0; k < max_k && tail < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        busy0 = int'(busy);
      end
      if (inject && k == 1) begin
        start = 1'b1; base = 8'd100; count = 9'd3;
      end
      if (inject && k == 2) start = 1'b0;
      case (rmode)
        1:       r = (k % 4 == 0) || (k % 4 == 3);
        2:       r = (k >= 8);
        default: r = 1'b1;
      endcase
      dout_ready = r;
      if (pv && !pr && (!dout_valid || dout !== pd)) stable_err++;
      if (dout_valid && first_k < 0) first_k = k;
      if (dout_valid && dout_ready) got.push_back(dout);
      if (k == 7) addr7 = int'(ram_addr);
      if (done) begin
        done_pulses++;
        if (done_k < 0) begin
          done_k    = k;
          busy_done = int'(busy);
        end
      end
      if (done_k >= 0) tail++;
      pv = dout_valid; pr = dout_ready; pd = dout;
    end
    start = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (ram_addr !== 8'd0) begin n_err++; $display("FAIL rst_ram_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL rst_ram_wren: got %b want 0", ram_wren); end
    n_cmp++; if (dout !== 16'd0) begin n_err++; $display("FAIL rst_dout: got %0d want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] g;
    run_burst(8'd0, 9'd4, 0, 1'b0, 30);
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL basic_len: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(i * 3)) begin n_err++; $display("FAIL basic_word%0d: got %0d want %0d", i, g, i * 3); end
    end
    n_cmp++; if (first_k !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", first_k); end
    n_cmp++; if (done_k !== 6) begin n_err++; $display("FAIL basic_done_time: got %0d want 6", done_k); end
    n_cmp++; if (done_pulses !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); end
    n_cmp++; if (busy0 !== 1) begin n_err++; $display("FAIL basic_busy_start: got %0d want 1", busy0); end
    n_cmp++; if (busy_done !== 0) begin n_err++; $display("FAIL basic_busy_at_done: got %0d want 0", busy_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_ready_toggle();
    logic [15:0] g;
    run_burst(8'd10, 9'd6, 1, 1'b0, 40);
    n_cmp++; if (got.size() !== 6) begin n_err++; $display("FAIL toggle_len: got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(30 + i * 3)) begin n_err++; $display("FAIL toggle_word%0d: got %0d want %0d", i, g, 30 + i * 3); end
    end
    n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL toggle_stable: got %0d violations want 0", stable_err); end
    n_cmp++; if (done_k !== 13) begin n_err++; $display("FAIL toggle_done_time: got %0d want 13", done_k); end
  endtask

  task automatic test_backpressure();
    logic [15:0] g;
    run_burst(8'd20, 9'd5, 2, 1'b0, 40);
    n_cmp++; if (addr7 !== 22) begin n_err++; $display("FAIL bp_addr_stall: got %0d want 22", addr7); end
    n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL bp_len: got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(60 + i * 3)) begin n_err++; $display("FAIL bp_word%0d: got %0d want %0d", i, g, 60 + i * 3); end
    end
    n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", stable_err); end
    n_cmp++; if (done_k !== 13) begin n_err++; $display("FAIL bp_done_time: got %0d want 13", done_k); end
  endtask

  task automatic test_top_boundary();
    logic [15:0] g;
    int          n_exp;
    int          dk_exp;
`ifdef MEMORY_READER_WRAP_EN
    n_exp = 8; dk_exp = 10;
`else
    n_exp = 4; dk_exp = 6;
`endif
    run_burst(8'd252, 9'd8, 0, 1'b0, 30);
    n_cmp++; if (got.size() !== n_exp) begin n_err++; $display("FAIL top_len: got %0d want %0d", got.size(), n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(((252 + i) % 256) * 3)) begin
        n_err++; $display("FAIL top_word%0d: got %0d want %0d", i, g, ((252 + i) % 256) * 3);
      end
    end
    n_cmp++; if (done_k !== dk_exp) begin n_err++; $display("FAIL top_done_time: got %0d want %0d", done_k, dk_exp); end
  endtask

  task automatic test_count_zero();
    run_burst(8'd7, 9'd0, 0, 1'b0, 10);
    n_cmp++; if (first_k !== -1) begin n_err++; $display("FAIL zero_valid: valid seen at %0d want never", first_k); end
    n_cmp++; if (done_k !== 0) begin n_err++; $display("FAIL zero_done_time: got %0d want 0", done_k); end
    n_cmp++; if (done_pulses !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", done_pulses); end
    n_cmp++; if (busy0 !== 0) begin n_err++; $display("FAIL zero_busy: got %0d want 0", busy0); end
  endtask

  task automatic test_count_full();
    logic [15:0] g;
    int          bad;
    run_burst(8'd0, 9'd256, 0, 1'b0, 300);
    n_cmp++; if (got.size() !== 256) begin n_err++; $display("FAIL full_len: got %0d want 256", got.size()); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(i * 3)) begin
        n_err++; bad++;
        if (bad <= 4) $display("FAIL full_word%0d: got %0d want %0d", i, g, i * 3);
      end
    end
    n_cmp++; if (done_k !== 258) begin n_err++; $display("FAIL full_done_time: got %0d want 258", done_k); end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] g;
    run_burst(8'd0, 9'd4, 0, 1'b1, 30);
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL busy_start_len: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(i * 3)) begin n_err++; $display("FAIL busy_start_word%0d: got %0d want %0d", i, g, i * 3); end
    end
    n_cmp++; if (done_k !== 6) begin n_err++; $display("FAIL busy_start_done_time: got %0d want 6", done_k); end
    n_cmp++; if (done_pulses !== 1) begin n_err++; $display("FAIL busy_start_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] g;
    @(negedge clk);
    start = 1'b1; base = 8'd0; count = 9'd6; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b want 1", dout_valid); end
    n_cmp++; if (ram_addr !== 8'd2) begin n_err++; $display("FAIL midrst_pre_addr: got %0d want 2", ram_addr); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", dout_valid); end
    n_cmp++; if (dout !== 16'd0) begin n_err++; $display("FAIL midrst_dout: got %0d want 0", dout); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (ram_addr !== 8'd0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
    run_burst(8'd5, 9'd2, 0, 1'b0, 20);
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL postrst_len: got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      g = (i < got.size()) ? got[i] : 16'hxxxx;
      n_cmp++; if (g !== 16'(15 + i * 3)) begin n_err++; $display("FAIL postrst_word%0d: got %0d want %0d", i, g, 15 + i * 3); end
    end
    n_cmp++; if (done_k !== 4) begin n_err++; $display("FAIL postrst_done_time: got %0d want 4", done_k); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base = '0; count = '0; dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_backpressure();
    test_top_boundary();
    test_count_zero();
    test_count_full();
    test_start_while_busy();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
